miss_fill_ctrl: RTL
===================

Name: miss_fill_ctrl

Overview:
Memory-side counterpart of the bank MSHR. It accepts newly allocated misses (MSHR id, line address, prefetch flag), issues line read requests to memory tagged with the MSHR id, and captures memory responses. It then drives the MSHR fill port (fill_valid/fill_id) together with the returned line data into the bank fill path. It tracks per-id outstanding state and reports protocol violations.

Parameters:
MSHR_SIZE, 8, number of MSHR entries; the memory tag space is 0..MSHR_SIZE-1.
LINE_ADDR_WIDTH, 26, line address width in bits.
CACHE_LINE_SIZE, 64, line size in bytes; the data path is CACHE_LINE_SIZE*8 bits.
MREQ_SIZE, 4, depth of the memory request queue; power of 2, at least 2.
MSHR_ADDR_WIDTH, $clog2(MSHR_SIZE), id width (derived).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
miss_valid  in  1  new miss allocated in MSHR
miss_id  in  MSHR_ADDR_WIDTH  allocated MSHR id
miss_addr  in  LINE_ADDR_WIDTH  line address
miss_prefetch  in  1  miss originated from prefetcher
miss_ready  out  1  queue can accept
mem_req_valid  out  1  memory read request valid
mem_req_addr  out  LINE_ADDR_WIDTH  request line address
mem_req_tag  out  MSHR_ADDR_WIDTH  request tag (= MSHR id)
mem_req_ready  in  1  memory accepts request
mem_rsp_valid  in  1  memory response valid
mem_rsp_tag  in  MSHR_ADDR_WIDTH  response tag
mem_rsp_data  in  CACHE_LINE_SIZE*8  line data
mem_rsp_ready  out  1  response accepted
fill_valid  out  1  fill to MSHR/bank valid
fill_id  out  MSHR_ADDR_WIDTH  MSHR id being filled
fill_data  out  CACHE_LINE_SIZE*8  line data
fill_prefetch  out  1  filled line was a prefetch
fill_ready  in  1  bank fill path accepts
pending_count  out  MSHR_ADDR_WIDTH+1  ids issued to memory and not yet filled
idle  out  1  queue empty, pending_count==0, no fill held
error  out  1  sticky protocol-violation flag

Behaviour:
- Interface reset: clk and reset, one clock domain; reset is synchronous and active-high. Reset clears the queue, the pending/prefetch tables, the response register and error.
- Output reset values: miss_ready=1 from the first cycle after reset; mem_req_valid=0, mem_rsp_ready=1, fill_valid=0, pending_count=0, idle=1, error=0. Table contents and data registers are don't-care.
- Handshakes: every fire is valid&&ready. Valid outputs stay asserted, with stable payload, until they fire. Outputs never depend combinationally on valid inputs.
- Request queue: circular FIFO of {id, addr, prefetch}, depth MREQ_SIZE.
  - miss_ready = !full. There is no bypass: an accepted miss appears on mem_req no earlier than the next cycle.
  - Push and pop in the same cycle are allowed when the queue is non-empty. When full, pop frees a slot only from the next cycle.
  - Pointers wrap modulo MREQ_SIZE. A separate count tracks occupancy, so full and empty are unambiguous.
- Request issue: on mem_req fire, set pending[tag]=1 and prefetch_tbl[tag]=queued prefetch bit; pending_count increments.
- Response capture: single-entry register.
  - mem_rsp_ready = !fill_valid || fill_ready. Back-to-back fills at one per cycle are sustained.
  - On mem_rsp fire, the register loads {tag, data, prefetch_tbl[tag]}, and fill_valid is asserted the next cycle.
- Fill: on fill fire, clear pending[fill_id] and decrement pending_count.
  - A request fire, a response fire and a fill fire may all occur in one cycle. pending_count moves by (+1 req) and (−1 fill), so the net change is 0 when both fire.
  - A request and a fill on the same id in one cycle: the set wins. Only legal after that id was released and reallocated.
- Responses may return out of order; no ordering is assumed between tags.
- Error conditions: each sets error=1 until reset. Behaviour otherwise continues.
  - mem_rsp fire with pending[tag]==0. The response is still forwarded.
  - miss fire with an id already pending or already queued (tracked by an in-queue bit per id).
- Reset mid-operation: all queued and pending state is dropped. Responses arriving after reset are flagged as errors.
- idle = (count==0) && (pending_count==0) && !fill_valid.

Test Plan:
- Single miss: id=3, addr=0x1234, prefetch=0, mem_req_ready=1 → mem_req the next cycle with tag=3, addr=0x1234, pending_count=1. Response tag=3 with data D → fill_valid the next cycle with fill_id=3, fill_data=D, fill_prefetch=0. pending_count returns to 0 and idle=1.
- Queue full: hold mem_req_ready=0 and push 4 misses (ids 0-3) → miss_ready=0 after the 4th. Release ready → requests issue in order 0,1,2,3 and miss_ready returns to 1 one cycle after the first pop.
- Out-of-order responses: issue ids 1,5,6; respond 6,1,5 → fills in order 6,1,5 with matching data, and pending_count steps 3→0.
- Backpressure: fill_ready=0 with one fill held → mem_rsp_ready=0 and the second response waits. fill_ready=1 → fills on consecutive cycles.
- Prefetch and error: a miss with prefetch=1 on id=2 → fill_prefetch=1. A response with tag=7 that was never issued → error=1 and stays 1.
- Reset with 2 queued and 2 pending → next cycle idle=1, pending_count=0, mem_req_valid=0.

Source files
------------

// File: rtl/miss_fill_ctrl.sv
// miss_fill_ctrl: memory-side half of the bank MSHR. Queues newly allocated
// misses, issues tagged line reads to memory, captures responses in a single
// register and hands them to the bank fill path. Tracks per-id pending state
// and raises a sticky error on protocol violations.
module miss_fill_ctrl #(
    parameter int MSHR_SIZE       = 8,
    parameter int LINE_ADDR_WIDTH = 26,
    parameter int CACHE_LINE_SIZE = 64,
    parameter int MREQ_SIZE       = 4,
    parameter int MSHR_ADDR_WIDTH = $clog2(MSHR_SIZE)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         miss_valid,
    input  logic [MSHR_ADDR_WIDTH-1:0]   miss_id,
    input  logic [LINE_ADDR_WIDTH-1:0]   miss_addr,
    input  logic                         miss_prefetch,
    output logic                         miss_ready,
    output logic                         mem_req_valid,
    output logic [LINE_ADDR_WIDTH-1:0]   mem_req_addr,
    output logic [MSHR_ADDR_WIDTH-1:0]   mem_req_tag,
    input  logic                         mem_req_ready,
    input  logic                         mem_rsp_valid,
    input  logic [MSHR_ADDR_WIDTH-1:0]   mem_rsp_tag,
    input  logic [CACHE_LINE_SIZE*8-1:0] mem_rsp_data,
    output logic                         mem_rsp_ready,
    output logic                         fill_valid,
    output logic [MSHR_ADDR_WIDTH-1:0]   fill_id,
    output logic [CACHE_LINE_SIZE*8-1:0] fill_data,
    output logic                         fill_prefetch,
    input  logic                         fill_ready,
    output logic [MSHR_ADDR_WIDTH:0]     pending_count,
    output logic                         idle,
    output logic                         error
);
    localparam int DATA_W = CACHE_LINE_SIZE * 8;
    localparam int PTR_W  = $clog2(MREQ_SIZE);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] Q_FULL = CNT_W'(MREQ_SIZE);

    typedef struct packed {
        logic [MSHR_ADDR_WIDTH-1:0] id;
        logic [LINE_ADDR_WIDTH-1:0] addr;
        logic                       pf;
    } mreq_t;

    mreq_t                      q_mem [MREQ_SIZE];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           q_count;
    mreq_t                      q_head;

    logic [MSHR_SIZE-1:0]       pending, pf_tbl, in_queue;
    logic [MSHR_ADDR_WIDTH:0]   pend_cnt;

    logic                       rsp_vld;
    logic [MSHR_ADDR_WIDTH-1:0] rsp_tag;
    logic [DATA_W-1:0]          rsp_data;
    logic                       rsp_pf;
    logic                       err;

    logic miss_fire, req_fire, rsp_fire, fill_fire;
    logic cnt_inc, cnt_dec;

    assign q_head        = q_mem[rd_ptr];
    assign miss_ready    = (q_count != Q_FULL);
    assign mem_req_valid = (q_count != '0);
    assign mem_req_addr  = q_head.addr;
    assign mem_req_tag   = q_head.id;
    assign mem_rsp_ready = !rsp_vld || fill_ready;
    assign fill_valid    = rsp_vld;
    assign fill_id       = rsp_tag;
    assign fill_data     = rsp_data;
    assign fill_prefetch = rsp_pf;
    assign pending_count = pend_cnt;
    assign error         = err;
    assign idle          = (q_count == '0) && (pend_cnt == '0) && !rsp_vld;

    assign miss_fire = miss_valid && miss_ready;
    assign req_fire  = mem_req_valid && mem_req_ready;
    assign rsp_fire  = mem_rsp_valid && mem_rsp_ready;
    assign fill_fire = rsp_vld && fill_ready;

    // Count follows the population of the pending table: a re-issue of an id
    // that is already pending, or a fill of an id that is not, leaves it alone.
    // A same-id request+fill keeps the bit set, so the count is unchanged.
    assign cnt_inc = req_fire && !pending[q_head.id];
    assign cnt_dec = fill_fire && pending[rsp_tag] && !(req_fire && (q_head.id == rsp_tag));

    // Queue storage: payload only, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (miss_fire) q_mem[wr_ptr] <= '{id: miss_id, addr: miss_addr, pf: miss_prefetch};
    end

    // Queue pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (miss_fire) wr_ptr <= wr_ptr + 1'b1;
            if (req_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({miss_fire, req_fire})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Per-id tables; a set on request issue overrides a clear from a fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            pf_tbl   <= '0;
            in_queue <= '0;
            pend_cnt <= '0;
        end else begin
            if (fill_fire) pending[rsp_tag] <= 1'b0;
            if (req_fire) begin
                pending[q_head.id]  <= 1'b1;
                pf_tbl[q_head.id]   <= q_head.pf;
                in_queue[q_head.id] <= 1'b0;
            end
            if (miss_fire) in_queue[miss_id] <= 1'b1;
            case ({cnt_inc, cnt_dec})
                2'b10:   pend_cnt <= pend_cnt + 1'b1;
                2'b01:   pend_cnt <= pend_cnt - 1'b1;
                default: pend_cnt <= pend_cnt;
            endcase
        end
    end

    // Response holding register valid: refilled in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (reset)          rsp_vld <= 1'b0;
        else if (rsp_fire)  rsp_vld <= 1'b1;
        else if (fill_fire) rsp_vld <= 1'b0;
    end

    // Response payload capture, prefetch bit looked up from the issue table.
    always_ff @(posedge clk) begin
        if (rsp_fire) begin
            rsp_tag  <= mem_rsp_tag;
            rsp_data <= mem_rsp_data;
            rsp_pf   <= pf_tbl[mem_rsp_tag];
        end
    end

    // Sticky error: unexpected response, or a miss on an id already in flight.
    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else if ((rsp_fire && !pending[mem_rsp_tag]) ||
                 (miss_fire && (pending[miss_id] || in_queue[miss_id])))
            err <= 1'b1;
    end
endmodule
